bram_arbiter: RTL
=================

Name: bram_arbiter

Overview:
- Shares one 256x16 single-clock block RAM between two requesters, A and B.
- The RAM has one write port and one registered read port with 1-cycle read latency.
- Arbitration is round-robin with at most one access per cycle. Read data is routed back to whichever requester issued the read.
- An embedded clear sequencer can fill the whole RAM with a constant. While it runs it owns the RAM.

Parameters:
- ADDR_W, 8, RAM address width; depth is 2**ADDR_W.
- DATA_W, 16, RAM data width.
- CLR_VAL, 0, word written to every location by the clear sequence.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- a_req  in  1  requester A access request; held until a_gnt.
- a_we  in  1  1 = write, 0 = read.
- a_addr  in  ADDR_W  A address.
- a_wdata  in  DATA_W  A write data.
- a_gnt  out  1  A granted this cycle (combinational).
- a_rvalid  out  1  A read data valid, 1-cycle pulse.
- a_rdata  out  DATA_W  A read data.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as A, for requester B.
- clr_start  in  1  pulse to start a clear.
- clr_busy  out  1  clear in progress.
- clr_done  out  1  1-cycle pulse when the clear completes.
- ram_w_en  out  1  RAM write enable.
- ram_r_en  out  1  RAM read enable.
- ram_w_addr  out  ADDR_W  RAM write address.
- ram_r_addr  out  ADDR_W  RAM read address.
- ram_data_in  out  DATA_W  RAM write data.
- ram_data_out  in  DATA_W  RAM read data.
- ram_valid_out  in  1  RAM read-valid; registered, not reset.

Behaviour:
- Clock/reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset values:
  - priority pointer = A; FSM = IDLE; clear counter = 0.
  - pending-read flags pend_a = pend_b = 0.
  - all registered outputs = 0: a_rvalid, b_rvalid, clr_busy, clr_done, a_rdata, b_rdata.
- Arbitration in IDLE (combinational, same cycle):
  - Only one of a_req/b_req high → that requester is granted.
  - Both high → the requester named by the priority pointer is granted.
  - On any grant, the pointer moves to the non-granted requester.
  - No request → pointer holds.
- Command mux:
  - Granted write: ram_w_en=1, ram_w_addr=addr, ram_data_in=wdata.
  - Granted read: ram_r_en=1, ram_r_addr=addr.
  - No grant: both enables 0; address/data outputs are don't-care, driven 0.
- Read return:
  - A granted read sets pend_x for exactly the next cycle.
  - In that cycle, x_rvalid = pend_x & ram_valid_out and x_rdata = ram_data_out.
  - Read latency is 1 cycle from grant to rvalid. Back-to-back reads return back-to-back.
  - Writes produce no response.
- FSM states and transitions:
  - IDLE: arbitration active. clr_start=1 → CLEAR with counter=0, clr_busy=1 from the next cycle. clr_start outranks a_req/b_req arriving in the same cycle; no grant is issued that cycle.
  - CLEAR: a_gnt = b_gnt = 0. Each cycle ram_w_en=1, ram_w_addr=counter, ram_data_in=CLR_VAL, counter++. After writing address 2**ADDR_W-1 → DONE. Total 256 write cycles for the defaults. clr_start is ignored here.
  - DONE: one cycle with no RAM access. clr_done=1, clr_busy=0 → IDLE. The priority pointer is unchanged across the whole clear.
- Boundary conditions:
  - A read granted in the cycle just before CLEAR is entered still returns its rvalid in the first CLEAR cycle.
  - Counter wrap: the counter is ADDR_W+1 bits wide; the MSB marks terminal.
  - Reset mid-clear → IDLE immediately, counter 0, no clr_done. The RAM is left partially cleared.
  - Reset with a read pending drops the response: no rvalid.
  - A request not granted remains pending; requesters must hold addr/data/we stable until gnt.
  - Same-address write then read on consecutive grants: the read returns the new data.

Decomposition:
- Shared package bram_pkg holds:
  - ADDR_W/DATA_W defaults.
  - FSM state encoding: IDLE=2'd0, CLEAR=2'd1, DONE=2'd2.
  - requester index constants: REQ_A=0, REQ_B=1.
- Sub-module rr_arb2: 2-way round-robin grant logic plus the pointer register, with an enable input that forces no grant during CLEAR/DONE.
- Command mux, read-return routing and FSM stay in bram_arbiter.
- The bench instantiates bram_arbiter together with the existing 256x16 RAM.

Test Plan:
- Single-requester round trip: A writes addr 0x10 = 0xBEEF; next cycle A reads 0x10 → a_gnt=1 both cycles; a_rvalid=1 exactly 1 cycle after the read grant, a_rdata=0xBEEF; b_rvalid stays 0.
- Contention: a_req and b_req both held high for 6 cycles, all reads, after reset → grant order A,B,A,B,A,B; each rvalid routed to the matching requester with that requester's address data.
- Clear: clr_start pulse with B requesting the same cycle →
  - no grant that cycle; clr_busy high for 256 cycles; ram_w_en=1 with addresses 0..255; clr_done pulses once;
  - b_gnt follows in IDLE; reading addr 5 returns 0x0000.
- Read in flight: grant A read of addr 3 (value 0x0004); clr_start next cycle → a_rvalid=1, a_rdata=0x0004 in the first CLEAR cycle.
- Reset mid-clear: assert rst at clear address 100 → clr_busy=0 asynchronously, no clr_done; after release A read of addr 200 returns its pre-clear value and addr 50 returns 0.
- Ignored restart: clr_start pulsed again mid-CLEAR → still exactly 256 writes and a single clr_done.

Source files
------------

// File: rtl/bram_pkg.sv
// bram_pkg: shared definitions for the two-requester block-RAM arbiter.
//   - default RAM geometry (address / data width)
//   - clear-sequencer FSM state encoding
//   - requester index constants used by the round-robin pointer
package bram_pkg;

    localparam int BRAM_ADDR_W = 8;
    localparam int BRAM_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/bram_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant logic with its priority pointer.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   en_i              0 forces no grant (clear sequencer owns the RAM)
//   req_a_i, req_b_i  requests
//   gnt_a_o, gnt_b_o  same-cycle (combinational) grants, at most one high
module rr_arb2
    import bram_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic req_a_i,
    input  logic req_b_i,
    output logic gnt_a_o,
    output logic gnt_b_o
);

    logic ptr_q;
    logic ptr_d;

    // Grant selection; the pointer always moves to the requester that lost.
    always_comb begin
        gnt_a_o = 1'b0;
        gnt_b_o = 1'b0;
        ptr_d   = ptr_q;
        if (en_i) begin
            if (req_a_i && (!req_b_i || (ptr_q == REQ_A))) begin
                gnt_a_o = 1'b1;
                ptr_d   = REQ_B;
            end else if (req_b_i) begin
                gnt_b_o = 1'b1;
                ptr_d   = REQ_A;
            end else begin
                ptr_d   = ptr_q;
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Priority pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= REQ_A;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/bram_arbiter.sv
// bram_arbiter: shares one single-clock block RAM (1 write port, 1 registered
// read port with 1-cycle latency) between requesters A and B, plus an
// embedded sequencer that fills the whole RAM with CLR_VAL.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   x_req/x_we/x_addr/x_wdata        requester x command (x = a, b)
//   x_gnt                            same-cycle grant
//   x_rvalid/x_rdata                 read response, one cycle after grant
//   clr_start/clr_busy/clr_done      clear control and status
//   ram_*                            RAM port signals
module bram_arbiter
    import bram_pkg::*;
#(
    parameter int                 ADDR_W  = BRAM_ADDR_W,
    parameter int                 DATA_W  = BRAM_DATA_W,
    parameter logic [DATA_W-1:0]  CLR_VAL = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              ram_w_en,
    output logic              ram_r_en,
    output logic [ADDR_W-1:0] ram_w_addr,
    output logic [ADDR_W-1:0] ram_r_addr,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out,
    input  logic              ram_valid_out
);

    state_e            state_q;
    logic [ADDR_W:0]   cnt_q;
    logic [ADDR_W:0]   cnt_inc_s;
    logic              clr_busy_q;
    logic              clr_done_q;
    logic              pend_a_q;
    logic              pend_b_q;
    logic              arb_en_s;

    // clr_start outranks requests arriving in the same cycle.
    assign arb_en_s  = (state_q == IDLE) && !clr_start;
    assign cnt_inc_s = cnt_q + {{ADDR_W{1'b0}}, 1'b1};

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .en_i    (arb_en_s),
        .req_a_i (a_req),
        .req_b_i (b_req),
        .gnt_a_o (a_gnt),
        .gnt_b_o (b_gnt)
    );

    // Clear sequencer: the extra counter bit flags that the last address was written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= {(ADDR_W+1){1'b0}};
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b0;
        end else begin
            clr_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (clr_start) begin
                        state_q    <= CLEAR;
                        cnt_q      <= {(ADDR_W+1){1'b0}};
                        clr_busy_q <= 1'b1;
                    end else begin
                        state_q    <= IDLE;
                    end
                end
                CLEAR: begin
                    if (cnt_inc_s[ADDR_W]) begin
                        state_q    <= DONE;
                        cnt_q      <= {(ADDR_W+1){1'b0}};
                        clr_busy_q <= 1'b0;
                        clr_done_q <= 1'b1;
                    end else begin
                        cnt_q      <= cnt_inc_s;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q    <= IDLE;
                    cnt_q      <= {(ADDR_W+1){1'b0}};
                    clr_busy_q <= 1'b0;
                end
            endcase
        end
    end

    // RAM command mux; unused address/data lines are held at zero.
    always_comb begin
        ram_w_en    = 1'b0;
        ram_r_en    = 1'b0;
        ram_w_addr  = {ADDR_W{1'b0}};
        ram_r_addr  = {ADDR_W{1'b0}};
        ram_data_in = {DATA_W{1'b0}};
        if (state_q == CLEAR) begin
            ram_w_en    = 1'b1;
            ram_w_addr  = cnt_q[ADDR_W-1:0];
            ram_data_in = CLR_VAL;
        end else if (a_gnt) begin
            if (a_we) begin
                ram_w_en    = 1'b1;
                ram_w_addr  = a_addr;
                ram_data_in = a_wdata;
            end else begin
                ram_r_en    = 1'b1;
                ram_r_addr  = a_addr;
            end
        end else if (b_gnt) begin
            if (b_we) begin
                ram_w_en    = 1'b1;
                ram_w_addr  = b_addr;
                ram_data_in = b_wdata;
            end else begin
                ram_r_en    = 1'b1;
                ram_r_addr  = b_addr;
            end
        end else begin
            ram_w_en = 1'b0;
        end
    end

    // Remember which requester owns the read that returns next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_a_q <= 1'b0;
            pend_b_q <= 1'b0;
        end else begin
            pend_a_q <= a_gnt && !a_we;
            pend_b_q <= b_gnt && !b_we;
        end
    end

    // Read data is forced to zero for the requester that does not own the return.
    assign a_rvalid = pend_a_q & ram_valid_out;
    assign b_rvalid = pend_b_q & ram_valid_out;
    assign a_rdata  = pend_a_q ? ram_data_out : {DATA_W{1'b0}};
    assign b_rdata  = pend_b_q ? ram_data_out : {DATA_W{1'b0}};
    assign clr_busy = clr_busy_q;
    assign clr_done = clr_done_q;

endmodule
